// File: rtl/game_clock_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_clock_timer_pkg
//  Description : Shared types, encodings and BCD helpers for the game clock
//                countdown timer (state encoding, MM:SS digit struct,
//                preset split and one-second BCD decrement).
//  Revision    : 1.0  initial release
// ============================================================================
package game_clock_timer_pkg;

    // Timer states; encodings are fixed so display/buzzer logic can decode them.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    // Upper limits of the BCD digits: ones digits and minute tens reach 9,
    // the seconds tens digit reaches 5.
    localparam logic [3:0] C_BCD_NINE = 4'd9;
    localparam logic [3:0] C_BCD_FIVE = 4'd5;

    // Largest representable preset values.
    localparam int unsigned C_MAX_MIN = 32'd99;
    localparam int unsigned C_MAX_SEC = 32'd59;

    // Current MM:SS value, one BCD digit per field, most significant first.
    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } mmss_t;

    // True when the value reads 00:00.
    function automatic logic mmss_is_zero(input mmss_t v);
        return (v == 16'h0000);
    endfunction

    // True when the value reads 00:01, i.e. the next decrement expires the clock.
    function automatic logic mmss_is_one(input mmss_t v);
        return (v == 16'h0001);
    endfunction

    // Split decimal minutes/seconds into BCD digits at elaboration time.
    // Out-of-range presets are clamped so the digits always stay valid.
    function automatic mmss_t mmss_preset(input int unsigned mins, input int unsigned secs);
        int unsigned m;
        int unsigned s;
        mmss_t       r;
        m = (mins > C_MAX_MIN) ? C_MAX_MIN : mins;
        s = (secs > C_MAX_SEC) ? C_MAX_SEC : secs;
        r.min_tens = 4'(m / 32'd10);
        r.min_ones = 4'(m % 32'd10);
        r.sec_tens = 4'(s / 32'd10);
        r.sec_ones = 4'(s % 32'd10);
        return r;
    endfunction

    // Subtract one second with a BCD borrow chain. 00:00 is returned unchanged,
    // which also guarantees min_tens never underflows.
    function automatic mmss_t mmss_decrement(input mmss_t v);
        mmss_t r;
        r = v;
        if (!mmss_is_zero(v)) begin
            if (v.sec_ones != 4'd0) begin
                r.sec_ones = v.sec_ones - 4'd1;
            end else begin
                r.sec_ones = C_BCD_NINE;
                if (v.sec_tens != 4'd0) begin
                    r.sec_tens = v.sec_tens - 4'd1;
                end else begin
                    r.sec_tens = C_BCD_FIVE;
                    if (v.min_ones != 4'd0) begin
                        r.min_ones = v.min_ones - 4'd1;
                    end else begin
                        r.min_ones = C_BCD_NINE;
                        r.min_tens = v.min_tens - 4'd1;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_clock_timer_tick_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tick_edge_sync
//  Description : Two-flop synchronizer for an asynchronous level input plus
//                a rising-edge detector producing a one-cycle pulse in the
//                destination clock domain. Falling edges produce nothing.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    // Metastability filter followed by a one-cycle history of the synced level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // High for exactly one cycle after each synchronized low-to-high transition.
    assign rise_o = sync2_q & ~hist_q;

endmodule
`default_nettype wire

// File: rtl/game_clock_timer.sv
`default_nettype none
// ============================================================================
//  Module      : game_clock_timer
//  Description : MM:SS BCD countdown timer for the scoreboard. Converts the
//                divider's slow square wave into one-cycle second ticks and
//                counts down under start/pause/load control, flagging expiry
//                with a level and a one-cycle strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module game_clock_timer
    import game_clock_timer_pkg::*;
#(
    parameter int unsigned START_MIN = 10,
    parameter int unsigned START_SEC = 0
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       tick_src,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       expired,
    output logic       expired_pulse
);

    // Preset digits resolved at elaboration; used for reset and for load.
    localparam mmss_t C_PRESET = mmss_preset(START_MIN, START_SEC);

    logic   sec_tick;
    state_e state_q;
    mmss_t  value_q;
    mmss_t  value_dec_d;
    logic   running_q;
    logic   expired_q;
    logic   expired_pulse_q;

    tick_edge_sync u_tick_sync (
        .clk_i   (clock_in),
        .rst_ni  (reset_n),
        .async_i (tick_src),
        .rise_o  (sec_tick)
    );

    // Value one second lower, ready for the next tick in RUN.
    assign value_dec_d = mmss_decrement(value_q);

    // Control FSM with BCD counter; status outputs are registered alongside the state.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            value_q         <= C_PRESET;
            running_q       <= 1'b0;
            expired_q       <= 1'b0;
            expired_pulse_q <= 1'b0;
        end else begin
            // The strobe is only ever raised on the cycle that enters EXPIRED.
            expired_pulse_q <= 1'b0;
            if (load) begin
                state_q   <= ST_IDLE;
                value_q   <= C_PRESET;
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_PAUSED: begin
                        // pause outranks start, so it also holds IDLE/PAUSED.
                        if (!pause && start) begin
                            if (mmss_is_zero(value_q)) begin
                                state_q         <= ST_EXPIRED;
                                expired_q       <= 1'b1;
                                expired_pulse_q <= 1'b1;
                            end else begin
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        // A tick coinciding with pause is deliberately lost.
                        if (pause) begin
                            state_q   <= ST_PAUSED;
                            running_q <= 1'b0;
                        end else if (sec_tick) begin
                            value_q <= value_dec_d;
                            if (mmss_is_one(value_q) || mmss_is_zero(value_q)) begin
                                state_q         <= ST_EXPIRED;
                                running_q       <= 1'b0;
                                expired_q       <= 1'b1;
                                expired_pulse_q <= 1'b1;
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        // Only load leaves EXPIRED; value is already 00:00.
                        state_q <= ST_EXPIRED;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                        expired_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign min_tens      = value_q.min_tens;
    assign min_ones      = value_q.min_ones;
    assign sec_tens      = value_q.sec_tens;
    assign sec_ones      = value_q.sec_ones;
    assign running       = running_q;
    assign expired       = expired_q;
    assign expired_pulse = expired_pulse_q;

endmodule
`default_nettype wire
